// File: rtl/operand_fetch_if.sv
// Issue-side bundle for operand_fetch: instruction input, RF read ports,
// write-back snoop, operand output and scoreboard status.
interface operand_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rs1;
    logic [ADDR_WIDTH-1:0] in_rs2;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_rd_we;
    logic [ADDR_WIDTH-1:0] rf_addr1;
    logic [DATA_WIDTH-1:0] rf_data1;
    logic [ADDR_WIDTH-1:0] rf_addr2;
    logic [DATA_WIDTH-1:0] rf_data2;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_enable;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_op1;
    logic [DATA_WIDTH-1:0] out_op2;
    logic [ADDR_WIDTH-1:0] out_rd;
    logic                  out_rd_we;
    logic                  sb_busy;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        input  rf_data1, rf_data2,
        input  wb_addr, wb_data, wb_enable,
        input  out_ready,
        output in_ready, rf_addr1, rf_addr2,
        output out_valid, out_op1, out_op2, out_rd, out_rd_we,
        output sb_busy
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        output rf_data1, rf_data2,
        output wb_addr, wb_data, wb_enable,
        output out_ready,
        input  in_ready, rf_addr1, rf_addr2,
        input  out_valid, out_op1, out_op2, out_rd, out_rd_we,
        input  sb_busy
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: reads the 2R1W register file, forwards same-cycle
// write-back data and stalls on RAW/WAW hazards via a pending-write scoreboard.
module operand_fetch #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input logic            clk,
    input logic            rst,
    operand_fetch_if.slave bus
);
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NREG       = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    function automatic logic is_zero(addr_t r);
        return ZERO_REG_EN && (r == '0);
    endfunction

    function automatic logic in_range(addr_t r);
        return int'(r) < DEPTH;
    endfunction

    logic [NREG-1:0] pending_q, pending_d;
    logic            out_valid_q, out_valid_d;
    data_t           op1_q, op1_d;
    data_t           op2_q, op2_d;
    addr_t           rd_q, rd_d;
    logic            rd_we_q, rd_we_d;

    logic  hit1, hit2, hitd;
    logic  pend1, pend2, pendd;
    logic  hazard, ready, accept;
    data_t fwd1, fwd2;

    assign bus.rf_addr1 = bus.in_rs1;
    assign bus.rf_addr2 = bus.in_rs2;

    assign hit1 = bus.wb_enable && (bus.wb_addr == bus.in_rs1) && !is_zero(bus.in_rs1);
    assign hit2 = bus.wb_enable && (bus.wb_addr == bus.in_rs2) && !is_zero(bus.in_rs2);
    assign hitd = bus.wb_enable && (bus.wb_addr == bus.in_rd) && !is_zero(bus.in_rd);

    // A write-back landing this cycle resolves the hazard it would otherwise cause.
    assign pend1 = pending_q[bus.in_rs1] && !hit1;
    assign pend2 = pending_q[bus.in_rs2] && !hit2;
    assign pendd = pending_q[bus.in_rd] && !hitd;

    assign hazard = pend1 || pend2 || (bus.in_rd_we && pendd);
    assign ready  = (!out_valid_q || bus.out_ready) && !hazard;
    assign accept = bus.in_valid && ready;

    assign fwd1 = is_zero(bus.in_rs1) ? '0 : hit1 ? bus.wb_data : bus.rf_data1;
    assign fwd2 = is_zero(bus.in_rs2) ? '0 : hit2 ? bus.wb_data : bus.rf_data2;

    always_comb begin
        pending_d   = pending_q;
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        if (bus.wb_enable && in_range(bus.wb_addr)) begin
            pending_d[bus.wb_addr] = 1'b0;
        end
        // Set after clear so a same-cycle set on the same register wins.
        if (accept && bus.in_rd_we && !is_zero(bus.in_rd) && in_range(bus.in_rd)) begin
            pending_d[bus.in_rd] = 1'b1;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            op1_d       = fwd1;
            op2_d       = fwd2;
            rd_d        = bus.in_rd;
            rd_we_d     = bus.in_rd_we;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_op1   = op1_q;
    assign bus.out_op2   = op2_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_rd_we = rd_we_q;
    assign bus.sb_busy   = |pending_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register file model, table-driven issue vectors
// and a scoreboard queue of expected operand bundles.
module tb_operand_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    operand_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    operand_fetch #(
        .DATA_WIDTH (32),
        .DEPTH      (32),
        .ZERO_REG_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [31:0] rf [32];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
            rf[0] <= 32'hDEAD;
            rf[3] <= 32'h11;
            rf[4] <= 32'h22;
        end else if (bus.wb_enable) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign bus.rf_data1 = rf[bus.rf_addr1];
    assign bus.rf_data2 = rf[bus.rf_addr2];

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] op1;
        logic [31:0] op2;
    } vec_t;

    exp_t q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (rst) return;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_op1", bus.out_op1, e.op1);
                chk("sb_op2", bus.out_op2, e.op2);
                chk("sb_rd", 32'(bus.out_rd), 32'(e.rd));
                chk("sb_rd_we", 32'(bus.out_rd_we), 32'(e.we));
            end
        end
        if (bus.in_valid && bus.in_ready) q.push_back(cur);
    endtask

    task automatic fin();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        fin();
    endtask

    task automatic issue(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                         logic we, logic [31:0] op1, logic [31:0] op2);
        bus.in_valid = 1'b1;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_rd    = rd;
        bus.in_rd_we = we;
        cur          = '{op1: op1, op2: op2, rd: rd, we: we};
    endtask

    task automatic wb(logic en, logic [4:0] a, logic [31:0] d);
        bus.wb_enable = en;
        bus.wb_addr   = a;
        bus.wb_data   = d;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{rs1: 5'd1,  rs2: 5'd2,  rd: 5'd6,  we: 1'b0, op1: 32'h101, op2: 32'h102};
        vecs[1] = '{rs1: 5'd0,  rs2: 5'd3,  rd: 5'd0,  we: 1'b0, op1: 32'h0,   op2: 32'h11};
        vecs[2] = '{rs1: 5'd31, rs2: 5'd30, rd: 5'd9,  we: 1'b0, op1: 32'h11F, op2: 32'h11E};
        vecs[3] = '{rs1: 5'd4,  rs2: 5'd4,  rd: 5'd10, we: 1'b0, op1: 32'h22,  op2: 32'h22};
        vecs[4] = '{rs1: 5'd2,  rs2: 5'd0,  rd: 5'd0,  we: 1'b0, op1: 32'h102, op2: 32'h0};

        bus.in_valid = 1'b0;
        bus.in_rs1 = '0;
        bus.in_rs2 = '0;
        bus.in_rd = '0;
        bus.in_rd_we = 1'b0;
        bus.out_ready = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        cur = '{op1: 0, op2: 0, rd: 0, we: 0};

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sb_busy", 32'(bus.sb_busy), 32'd0);
        chk("rst_op1", bus.out_op1, 32'd0);
        chk("rst_op2", bus.out_op2, 32'd0);
        chk("rst_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_rd_we", 32'(bus.out_rd_we), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we,
                  vecs[i].op1, vecs[i].op2);
            @(negedge clk);
            chk("tbl_in_ready", 32'(bus.in_ready), 32'd1);
            fin();
        end
        bus.in_valid = 1'b0;
        step();

        issue(5'd3, 5'd4, 5'd5, 1'b1, 32'h11, 32'h22);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t2_op1", bus.out_op1, 32'h11);
        chk("t2_sb_busy", 32'(bus.sb_busy), 32'd1);
        fin();

        issue(5'd5, 5'd1, 5'd11, 1'b0, 32'hAB, 32'h101);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("raw_stall", 32'(bus.in_ready), 32'd0);
            fin();
        end
        wb(1'b1, 5'd5, 32'hAB);
        @(negedge clk);
        chk("raw_wb_ready", 32'(bus.in_ready), 32'd1);
        fin();
        wb(1'b0, 5'd0, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("raw_op1", bus.out_op1, 32'hAB);
        chk("raw_sb_idle", 32'(bus.sb_busy), 32'd0);
        fin();

        bus.out_ready = 1'b0;
        issue(5'd3, 5'd4, 5'd12, 1'b0, 32'h11, 32'h22);
        step();
        issue(5'd6, 5'd7, 5'd13, 1'b0, 32'h106, 32'h107);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_op1", bus.out_op1, 32'h11);
            chk("bp_op2", bus.out_op2, 32'h22);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            fin();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(bus.in_ready), 32'd1);
        fin();
        bus.in_valid = 1'b0;
        step();

        issue(5'd1, 5'd2, 5'd0, 1'b1, 32'h101, 32'h102);
        step();
        issue(5'd0, 5'd0, 5'd14, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("z_in_ready", 32'(bus.in_ready), 32'd1);
        chk("z_sb_busy", 32'(bus.sb_busy), 32'd0);
        fin();
        wb(1'b1, 5'd0, 32'hFF);
        issue(5'd0, 5'd3, 5'd14, 1'b0, 32'h0, 32'h11);
        @(negedge clk);
        chk("z_wb_ready", 32'(bus.in_ready), 32'd1);
        fin();
        wb(1'b0, 5'd0, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("z_op1", bus.out_op1, 32'h0);
        chk("z_sb_after", 32'(bus.sb_busy), 32'd0);
        fin();

        issue(5'd1, 5'd2, 5'd7, 1'b1, 32'h101, 32'h102);
        step();
        issue(5'd3, 5'd4, 5'd7, 1'b1, 32'h11, 32'h22);
        @(negedge clk);
        chk("waw_stall", 32'(bus.in_ready), 32'd0);
        fin();
        wb(1'b1, 5'd7, 32'h77);
        @(negedge clk);
        chk("sc_ready", 32'(bus.in_ready), 32'd1);
        fin();
        wb(1'b0, 5'd0, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("sc_pending", 32'(bus.sb_busy), 32'd1);
        fin();
        issue(5'd7, 5'd0, 5'd15, 1'b0, 32'h99, 32'h0);
        @(negedge clk);
        chk("sc_raw_stall", 32'(bus.in_ready), 32'd0);
        fin();
        wb(1'b1, 5'd7, 32'h99);
        @(negedge clk);
        chk("sc_fwd_ready", 32'(bus.in_ready), 32'd1);
        fin();
        wb(1'b0, 5'd0, 32'd0);
        bus.in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("sc_idle", 32'(bus.sb_busy), 32'd0);
        fin();

        issue(5'd1, 5'd2, 5'd20, 1'b1, 32'h101, 32'h102);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_sb_busy", 32'(bus.sb_busy), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
